// File: rtl/quad_count_ctrl.sv
// Quadrature encoder front end for a 74169-style up/down counter.
// Synchronises, filters and 4x-decodes PHA/PHB and issues index preloads.
module quad_count_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int IDX_LOAD_EN = 1
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       PHA,
  input  logic       PHB,
  input  logic       IDX,
  input  logic [3:0] PRESET,
  input  logic       HOLDB,
  input  logic       CLR,
  output logic       U_DB,
  output logic       ENPB,
  output logic       ENTB,
  output logic       LOADB,
  output logic [3:0] A,
  output logic       ERR
);

  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic {UNPRIMED, TRACK} st_t;

  logic [SYNC_STAGES-1:0] pha_sync_q;
  logic [SYNC_STAGES-1:0] phb_sync_q;
  logic [SYNC_STAGES-1:0] idx_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;

  logic [2:0]    smp;
  logic [2:0]    last_q, last_d;
  logic [2:0]    filt_q, filt_d;
  logic [2:0]    fvld_q, fvld_d;
  logic [CW-1:0] run_q [3];
  logic [CW-1:0] run_d [3];

  st_t        state_q, state_d;
  logic [1:0] ref_q, ref_d;
  logic       idxp_q, idxp_d;
  logic [1:0] ab, chg, nxt_up;
  logic       evt, dbl, up, rise;

  logic       load, cnt;
  logic       enpb_q, enpb_d;
  logic       loadb_q, loadb_d;
  logic       ud_q, ud_d;
  logic [3:0] a_q, a_d;
  logic       err_q, err_d;

  // Synchroniser chains; fill_q marks when the chain holds real pin samples.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pha_sync_q <= '0;
      phb_sync_q <= '0;
      idx_sync_q <= '0;
      fill_q     <= '0;
    end else begin
      pha_sync_q <= {pha_sync_q[SYNC_STAGES-2:0], PHA};
      phb_sync_q <= {phb_sync_q[SYNC_STAGES-2:0], PHB};
      idx_sync_q <= {idx_sync_q[SYNC_STAGES-2:0], IDX};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign smp = {pha_sync_q[SYNC_STAGES-1],
                phb_sync_q[SYNC_STAGES-1],
                idx_sync_q[SYNC_STAGES-1]};

  // Run-length filter: accept a level after FILT_LEN equal samples.
  always_comb begin
    last_d = last_q;
    filt_d = filt_q;
    fvld_d = fvld_q;
    for (int i = 0; i < 3; i++) begin
      run_d[i] = run_q[i];
      if (fill_q[SYNC_STAGES-1]) begin
        if (smp[i] != last_q[i] || run_q[i] == '0)
          run_d[i] = CW'(1);
        else if (run_q[i] < CW'(FILT_LEN))
          run_d[i] = run_q[i] + CW'(1);
        last_d[i] = smp[i];
        if (run_d[i] == CW'(FILT_LEN)) begin
          filt_d[i] = smp[i];
          fvld_d[i] = 1'b1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      last_q <= '0;
      filt_q <= '0;
      fvld_q <= '0;
      for (int i = 0; i < 3; i++) run_q[i] <= '0;
    end else begin
      last_q <= last_d;
      filt_q <= filt_d;
      fvld_q <= fvld_d;
      for (int i = 0; i < 3; i++) run_q[i] <= run_d[i];
    end
  end

  assign ab     = filt_q[2:1];
  assign chg    = ab ^ ref_q;
  assign nxt_up = {ref_q[0], ~ref_q[1]};

  // Decoder state register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= UNPRIMED;
      ref_q   <= '0;
      idxp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      idxp_q  <= idxp_d;
    end
  end

  // Decoder next state: prime on first valid level, then track Gray steps.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    idxp_d  = idxp_q;
    evt     = 1'b0;
    dbl     = 1'b0;
    up      = 1'b0;
    rise    = 1'b0;
    unique case (state_q)
      UNPRIMED: begin
        if (&fvld_q) begin
          state_d = TRACK;
          ref_d   = ab;
          idxp_d  = filt_q[0];
        end
      end
      TRACK: begin
        ref_d  = ab;
        idxp_d = filt_q[0];
        evt    = ^chg;
        dbl    = &chg;
        up     = (ab == nxt_up);
        rise   = filt_q[0] & ~idxp_q;
      end
      default: state_d = UNPRIMED;
    endcase
  end

  // Output decode: load beats count, hold masks count only.
  always_comb begin
    load    = rise && (IDX_LOAD_EN != 0);
    cnt     = evt && HOLDB && !load;
    enpb_d  = ~cnt;
    loadb_d = ~load;
    a_d     = load ? PRESET : a_q;
    ud_d    = cnt ? up : ud_q;
    err_d   = err_q;
    unique case (1'b1)
      dbl:     err_d = 1'b1;
      CLR:     err_d = 1'b0;
      default: err_d = err_q;
    endcase
  end

  // Registered counter control pins.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      enpb_q  <= 1'b1;
      loadb_q <= 1'b1;
      ud_q    <= 1'b1;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      enpb_q  <= enpb_d;
      loadb_q <= loadb_d;
      ud_q    <= ud_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  assign ENPB  = enpb_q;
  assign ENTB  = enpb_q;
  assign LOADB = loadb_q;
  assign U_DB  = ud_q;
  assign A     = a_q;
  assign ERR   = err_q;

endmodule
